zbt_arbiter: RTL and testbench
==============================

# zbt_arbiter

Shares one ZBT SRAM port (19-bit address, 36-bit word) between three requesters: the display read path, the camera write path and the processing read/write path. It sits between those requesters and the ZBT pin driver. It issues at most one command per clock. It tags each read so the returned word reaches the requester that issued it, after the fixed SRAM read latency.

## Interface
- READ_LATENCY, 2, cycles from a command on zbt_addr to its data on zbt_read_data.
- clk  in  1  system clock (the pixel/ZBT clock).
- reset  in  1  asynchronous, active-high.
- disp_req  in  1  display read request. Each cycle it is high is one read, with no ack.
- disp_addr  in  19  display read address.
- disp_read_data  out  36  returned display word.
- disp_valid  out  1  one-cycle pulse; disp_read_data is valid.
- cam_req  in  1  camera write request. Held high until cam_ack.
- cam_addr  in  19  camera write address.
- cam_write_data  in  36  camera write word.
- cam_ack  out  1  one-cycle pulse; the write has been issued.
- proc_req  in  1  processing request. Held high until proc_ack.
- proc_we  in  1  1 = write, 0 = read.
- proc_addr  in  19  processing address.
- proc_write_data  in  36  processing write word.
- proc_ack  out  1  one-cycle pulse; the command has been issued.
- proc_read_data  out  36  returned processing word.
- proc_valid  out  1  one-cycle pulse; proc_read_data is valid.
- zbt_addr  out  19  SRAM address.
- zbt_we  out  1  SRAM write enable.
- zbt_write_data  out  36  SRAM write word.
- zbt_read_data  in  36  SRAM read word.
- grant  out  2  owner of the current command: 0 none, 1 display, 2 camera, 3 processing.

## Operation
- Each clock the arbiter selects one eligible requester. Priority is fixed: display first. Camera and processing then share the remaining cycles by round-robin.
- Round-robin: a last_grant bit records whether camera or processing was granted last. When both request in the same cycle, the one not granted last wins. last_grant updates only on camera or processing grants.
- A port whose ack is high in the current cycle is not eligible in that cycle. This prevents a double issue while the requester is still dropping req.
- Display is never stalled. The system is responsible for keeping the display duty cycle low enough that camera and processing still make progress.
- Issue: zbt_addr, zbt_we, zbt_write_data, grant and the ack pulse are all registered. They appear together in the cycle after the one in which the grant was decided.
- Idle cycle: zbt_we=0 and grant=0. zbt_addr and zbt_write_data hold their previous values.
- Read tag pipeline, READ_LATENCY stages of {valid, owner}: a display read or a processing read (proc_we=0) enters with valid=1. Writes and idle cycles enter with valid=0.
- At the pipeline output, zbt_read_data is registered into disp_read_data or proc_read_data, and the matching valid pulses. The other port's data register holds its value.
- Reset: every output is 0, the tag pipeline is cleared and last_grant=processing, so camera wins the first tie. Reads in flight when reset asserts are discarded and produce no valid pulse.

## Timing
- Requests sampled at edge t: command, grant and ack visible in cycle t+1.
- A read issued in cycle C is answered by zbt_read_data in cycle C+READ_LATENCY. disp_valid or proc_valid is high in cycle C+READ_LATENCY+1, so total latency from the request edge is READ_LATENCY+2 cycles.
- Maximum rate: display 1 command per cycle. Camera and processing are each at most every other cycle, because of the ack mask. When both are requesting and display is idle, they alternate and each gets every other cycle.
- Read returns come back in issue order. A display return and a processing return never share a cycle.
- If a requester deasserts req before ack, the request is withdrawn and no command is issued for it.

## Structure
- Package zbt_pkg holds ZBT_ADDR_W=19, ZBT_DATA_W=36, and the owner encoding constants OWN_NONE, OWN_DISP, OWN_CAM, OWN_PROC. The ZBT pin driver and the requesters share this package.
- Sub-module zbt_read_tag_pipe: a parameterised READ_LATENCY-deep shift register of {valid, owner}, with asynchronous clear.
- Top level: grant logic, last_grant, command and ack registers, return routing.

## Test plan
- Reset, then disp_req alone with disp_addr=0x00010 in cycle 0, where the memory model holds 0x123456789 at that address. Required: zbt_addr=0x00010, grant=1 in cycle 1; disp_valid with disp_read_data=0x123456789 in cycle 4.
- cam_req and proc_req both held from reset, display idle. Required: grants alternate cam, proc, cam, proc in cycles 1–4. Each ack pulses for exactly one cycle, and no address is issued twice.
- disp_req held for 8 cycles while cam_req is pending. Required: 8 display grants, then cam_ack in the cycle after disp_req drops.
- Processing read at 0x7FFFF, followed immediately by a display read at 0x00000. Required: proc_valid returns the 0x7FFFF data first, then disp_valid returns the 0x00000 data one cycle later, with no cross-routing.
- Processing write of 0xFFFFFFFFF to 0x00100. Required: zbt_we=1 with zbt_write_data=0xFFFFFFFFF and proc_ack in the same cycle, and no proc_valid afterwards.
- Display read issued in cycle 1, with reset pulsed in cycle 2. Required: all outputs 0 during reset, and no disp_valid in any later cycle for that read.

Source files
------------

// File: rtl/zbt_pkg.sv
// Shared ZBT SRAM widths, owner encoding and the read-tag record.
package zbt_pkg;
  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CAM  = 2'd2,
    OWN_PROC = 2'd3
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;
endpackage

// File: rtl/zbt_arbiter_if.sv
// Requester and SRAM-side bundle of the ZBT arbiter.
interface zbt_arbiter_if;
  import zbt_pkg::*;

  logic                  disp_req;
  logic [ZBT_ADDR_W-1:0] disp_addr;
  logic [ZBT_DATA_W-1:0] disp_read_data;
  logic                  disp_valid;

  logic                  cam_req;
  logic [ZBT_ADDR_W-1:0] cam_addr;
  logic [ZBT_DATA_W-1:0] cam_write_data;
  logic                  cam_ack;

  logic                  proc_req;
  logic                  proc_we;
  logic [ZBT_ADDR_W-1:0] proc_addr;
  logic [ZBT_DATA_W-1:0] proc_write_data;
  logic                  proc_ack;
  logic [ZBT_DATA_W-1:0] proc_read_data;
  logic                  proc_valid;

  logic [ZBT_ADDR_W-1:0] zbt_addr;
  logic                  zbt_we;
  logic [ZBT_DATA_W-1:0] zbt_write_data;
  logic [ZBT_DATA_W-1:0] zbt_read_data;
  logic [1:0]            grant;

  modport slave (
    input  disp_req, disp_addr, cam_req, cam_addr, cam_write_data,
           proc_req, proc_we, proc_addr, proc_write_data, zbt_read_data,
    output disp_read_data, disp_valid, cam_ack, proc_ack, proc_read_data,
           proc_valid, zbt_addr, zbt_we, zbt_write_data, grant
  );

  modport master (
    output disp_req, disp_addr, cam_req, cam_addr, cam_write_data,
           proc_req, proc_we, proc_addr, proc_write_data, zbt_read_data,
    input  disp_read_data, disp_valid, cam_ack, proc_ack, proc_read_data,
           proc_valid, zbt_addr, zbt_we, zbt_write_data, grant
  );
endinterface

// File: rtl/zbt_read_tag_pipe.sv
// Delay line of {valid, owner} tags matching the SRAM read latency.
module zbt_read_tag_pipe import zbt_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      for (int i = DEPTH-1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= tag_in;
    end
  end

  assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/zbt_arbiter.sv
// Three-way ZBT port arbiter: display has fixed priority, camera and processing
// round-robin; read returns are steered back by a tag pipeline.
module zbt_arbiter import zbt_pkg::*; #(
  parameter int READ_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  zbt_arbiter_if.slave bus
);
  owner_e                sel, grant_q;
  logic                  last_proc;
  logic                  cam_ok, proc_ok;
  logic                  cam_ack_q, proc_ack_q, we_q;
  logic [ZBT_ADDR_W-1:0] addr_q;
  logic [ZBT_DATA_W-1:0] wdata_q;
  logic                  disp_valid_q, proc_valid_q;
  logic [ZBT_DATA_W-1:0] disp_data_q, proc_data_q;
  tag_t                  tag_in, tag_out;

  // An acked port may still show req this cycle; masking it avoids a re-issue.
  assign cam_ok  = bus.cam_req  & ~cam_ack_q;
  assign proc_ok = bus.proc_req & ~proc_ack_q;

  always_comb begin
    sel = OWN_NONE;
    if (bus.disp_req)          sel = OWN_DISP;
    else if (cam_ok && proc_ok) sel = last_proc ? OWN_CAM : OWN_PROC;
    else if (cam_ok)           sel = OWN_CAM;
    else if (proc_ok)          sel = OWN_PROC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= OWN_NONE;
      last_proc  <= 1'b1;
      cam_ack_q  <= 1'b0;
      proc_ack_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      grant_q    <= sel;
      cam_ack_q  <= (sel == OWN_CAM);
      proc_ack_q <= (sel == OWN_PROC);
      case (sel)
        OWN_DISP: begin
          addr_q <= bus.disp_addr;
          we_q   <= 1'b0;
        end
        OWN_CAM: begin
          addr_q    <= bus.cam_addr;
          we_q      <= 1'b1;
          wdata_q   <= bus.cam_write_data;
          last_proc <= 1'b0;
        end
        OWN_PROC: begin
          addr_q    <= bus.proc_addr;
          we_q      <= bus.proc_we;
          last_proc <= 1'b1;
          if (bus.proc_we) wdata_q <= bus.proc_write_data;
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

  // Tags follow the registered command, so the pipe tail lines up with read data.
  always_comb begin
    tag_in.owner = grant_q;
    tag_in.valid = (grant_q == OWN_DISP) || ((grant_q == OWN_PROC) && !we_q);
  end

  zbt_read_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      proc_valid_q <= 1'b0;
      disp_data_q  <= '0;
      proc_data_q  <= '0;
    end else begin
      disp_valid_q <= tag_out.valid && (tag_out.owner == OWN_DISP);
      proc_valid_q <= tag_out.valid && (tag_out.owner == OWN_PROC);
      if (tag_out.valid && tag_out.owner == OWN_DISP) disp_data_q <= bus.zbt_read_data;
      if (tag_out.valid && tag_out.owner == OWN_PROC) proc_data_q <= bus.zbt_read_data;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.cam_ack        = cam_ack_q;
  assign bus.proc_ack       = proc_ack_q;
  assign bus.zbt_addr       = addr_q;
  assign bus.zbt_we         = we_q;
  assign bus.zbt_write_data = wdata_q;
  assign bus.disp_valid     = disp_valid_q;
  assign bus.disp_read_data = disp_data_q;
  assign bus.proc_valid     = proc_valid_q;
  assign bus.proc_read_data = proc_data_q;
endmodule

// File: tb/tb_zbt_arbiter.sv
// Bench for zbt_arbiter: directed vectors, corner sequences, randomized agents vs. a reference model.
module tb_zbt_arbiter;
  import zbt_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zbt_arbiter_if bus ();
  zbt_arbiter #(.READ_LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  // SRAM model: 2-cycle read latency, write on the command's following edge.
  logic [35:0] mem [0:524287];
  logic [35:0] d1, d2;
  logic        mem_init = 1'b0;

  function automatic logic [35:0] fill(input logic [18:0] a);
    if (a == 19'h00010) return 36'h123456789;
    return {a, ~a[16:0]};
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 524288; a++) mem[a] <= fill(19'(a));
      mem_init <= 1'b1;
    end else if (bus.zbt_we) begin
      mem[bus.zbt_addr] <= bus.zbt_write_data;
    end
    d1 <= mem[bus.zbt_addr];
    d2 <= d1;
  end
  assign bus.zbt_read_data = d2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.cam_req = 0; bus.cam_addr = '0; bus.cam_write_data = '0;
    bus.proc_req = 0; bus.proc_we = 0; bus.proc_addr = '0; bus.proc_write_data = '0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_grant"}, 64'(bus.grant), 0);
    chk({p, "_we"}, 64'(bus.zbt_we), 0);
    chk({p, "_addr"}, 64'(bus.zbt_addr), 0);
    chk({p, "_wdata"}, 64'(bus.zbt_write_data), 0);
    chk({p, "_acks"}, 64'({bus.cam_ack, bus.proc_ack}), 0);
    chk({p, "_valids"}, 64'({bus.disp_valid, bus.proc_valid}), 0);
    chk({p, "_rdata"}, 64'(bus.disp_read_data | bus.proc_read_data), 0);
  endtask

  task automatic do_reset(input string p);
    idle_inputs();
    reset = 1;
    repeat (3) tick();
    chk_zero(p);
    reset = 0;
  endtask

  typedef struct {
    logic       d, c, p;
    logic [1:0] g;
    logic       ca, pa;
  } vec_t;
  vec_t tbl[16];

  typedef struct {
    int          due;
    logic [1:0]  own;
    logic [35:0] data;
  } ret_t;
  ret_t q[$];

  logic [18:0] ca_addr, pa_addr, m_addr;
  logic        m_ca, m_pa, m_last_proc, sd, sc, sp, swe, ce, pe, exp_we, edv, epv, seen;
  logic [1:0]  sel;
  logic [18:0] sda, sca, spa;
  logic [35:0] scd, spd, edata;
  int          cyc;

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = '{0, 1, 1, (i % 2 == 0) ? 2'd2 : 2'd3, i % 2 == 0, i % 2 == 1};
    for (int i = 4; i < 12; i++) tbl[i] = '{1, 1, 0, 2'd1, 0, 0};
    tbl[12] = '{0, 1, 0, 2'd2, 1, 0};
    tbl[13] = '{0, 1, 0, 2'd0, 0, 0};
    tbl[14] = '{0, 0, 1, 2'd3, 0, 1};
    tbl[15] = '{0, 0, 0, 2'd0, 0, 0};

    // Single display read, full latency.
    do_reset("rst0");
    bus.disp_req = 1; bus.disp_addr = 19'h00010;
    tick();
    chk("t1_grant", 64'(bus.grant), 1);
    chk("t1_addr", 64'(bus.zbt_addr), 64'h10);
    chk("t1_we", 64'(bus.zbt_we), 0);
    bus.disp_req = 0;
    tick(); chk("t1_valid_c2", 64'(bus.disp_valid), 0);
    tick(); chk("t1_valid_c3", 64'(bus.disp_valid), 0);
    tick();
    chk("t1_valid_c4", 64'(bus.disp_valid), 1);
    chk("t1_data", 64'(bus.disp_read_data), 64'h123456789);

    // Table: cam/proc alternation, display hold-off, ack mask.
    do_reset("rst1");
    ca_addr = 19'h01000; pa_addr = 19'h02000;
    bus.cam_write_data = 36'hCAFE; bus.proc_we = 1; bus.proc_write_data = 36'hBEEF;
    for (int i = 0; i < 16; i++) begin
      bus.disp_req = tbl[i].d; bus.cam_req = tbl[i].c; bus.proc_req = tbl[i].p;
      bus.disp_addr = 19'(19'h300 + i); bus.cam_addr = ca_addr; bus.proc_addr = pa_addr;
      tick();
      chk($sformatf("tbl%0d_grant", i), 64'(bus.grant), 64'(tbl[i].g));
      chk($sformatf("tbl%0d_acks", i), 64'({bus.cam_ack, bus.proc_ack}), 64'({tbl[i].ca, tbl[i].pa}));
      if (tbl[i].g == 2'd2) chk($sformatf("tbl%0d_caddr", i), 64'(bus.zbt_addr), 64'(ca_addr));
      if (tbl[i].g == 2'd3) chk($sformatf("tbl%0d_paddr", i), 64'(bus.zbt_addr), 64'(pa_addr));
      if (tbl[i].g == 2'd1) chk($sformatf("tbl%0d_daddr", i), 64'(bus.zbt_addr), 64'(19'h300 + i));
      if (tbl[i].ca) ca_addr = ca_addr + 1;
      if (tbl[i].pa) pa_addr = pa_addr + 1;
    end
    idle_inputs();
    repeat (4) tick();

    // Processing read at top address then display read at 0: ordered, unswapped.
    bus.proc_req = 1; bus.proc_we = 0; bus.proc_addr = 19'h7FFFF;
    tick();
    chk("pd_grant_p", 64'({bus.grant, bus.proc_ack}), 64'({2'd3, 1'b1}));
    bus.proc_req = 0; bus.disp_req = 1; bus.disp_addr = 19'h00000;
    tick();
    chk("pd_grant_d", 64'(bus.grant), 1);
    bus.disp_req = 0;
    tick();
    tick();
    chk("pd_pvalid", 64'({bus.proc_valid, bus.disp_valid}), 64'b10);
    chk("pd_pdata", 64'(bus.proc_read_data), 64'hFFFFE0000);
    tick();
    chk("pd_dvalid", 64'({bus.proc_valid, bus.disp_valid}), 64'b01);
    chk("pd_ddata", 64'(bus.disp_read_data), 64'h00001FFFF);

    // Processing write of all-ones.
    bus.proc_req = 1; bus.proc_we = 1; bus.proc_addr = 19'h00100; bus.proc_write_data = 36'hFFFFFFFFF;
    tick();
    chk("wr_cmd", 64'({bus.zbt_we, bus.proc_ack, bus.grant}), 64'({1'b1, 1'b1, 2'd3}));
    chk("wr_data", 64'(bus.zbt_write_data), 64'hFFFFFFFFF);
    chk("wr_addr", 64'(bus.zbt_addr), 64'h100);
    bus.proc_req = 0;
    seen = 0;
    repeat (5) begin tick(); seen = seen | bus.proc_valid; end
    chk("wr_no_pvalid", 64'(seen), 0);
    chk("wr_mem", 64'(mem[19'h00100]), 64'hFFFFFFFFF);

    // Reset while a display read is in flight.
    bus.disp_req = 1; bus.disp_addr = 19'h00020;
    tick();
    chk("rr_grant", 64'(bus.grant), 1);
    bus.disp_req = 0;
    reset = 1;
    #1;
    chk_zero("rr_async");
    tick(); tick();
    reset = 0;
    seen = 0;
    repeat (6) begin tick(); seen = seen | bus.disp_valid; end
    chk("rr_no_dvalid", 64'(seen), 0);

    // Randomized agents vs. reference model.
    do_reset("rst2");
    m_ca = 0; m_pa = 0; m_last_proc = 1; m_addr = '0; cyc = 0;
    for (int i = 0; i < 1500; i++) begin
      sd = bus.disp_req; sc = bus.cam_req; sp = bus.proc_req; swe = bus.proc_we;
      sda = bus.disp_addr; sca = bus.cam_addr; spa = bus.proc_addr;
      scd = bus.cam_write_data; spd = bus.proc_write_data;
      ce = sc && !m_ca; pe = sp && !m_pa;
      if (sd) sel = 2'd1;
      else if (ce && pe) sel = m_last_proc ? 2'd2 : 2'd3;
      else if (ce) sel = 2'd2;
      else if (pe) sel = 2'd3;
      else sel = 2'd0;
      if (sel == 2'd2) m_last_proc = 0;
      if (sel == 2'd3) m_last_proc = 1;
      tick();
      cyc++;
      chk("rnd_grant", 64'(bus.grant), 64'(sel));
      chk("rnd_acks", 64'({bus.cam_ack, bus.proc_ack}), 64'({sel == 2'd2, sel == 2'd3}));
      exp_we = (sel == 2'd2) || (sel == 2'd3 && swe);
      chk("rnd_we", 64'(bus.zbt_we), 64'(exp_we));
      if (sel == 2'd1) m_addr = sda;
      if (sel == 2'd2) m_addr = sca;
      if (sel == 2'd3) m_addr = spa;
      chk("rnd_addr", 64'(bus.zbt_addr), 64'(m_addr));
      if (sel == 2'd2) chk("rnd_wdata", 64'(bus.zbt_write_data), 64'(scd));
      if (sel == 2'd3 && swe) chk("rnd_wdata", 64'(bus.zbt_write_data), 64'(spd));
      if (sel == 2'd1 || (sel == 2'd3 && !swe)) q.push_back('{cyc + 3, sel, mem[m_addr]});
      edv = 0; epv = 0; edata = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        edv = (q[0].own == 2'd1); epv = (q[0].own == 2'd3); edata = q[0].data;
        void'(q.pop_front());
      end
      chk("rnd_valids", 64'({bus.disp_valid, bus.proc_valid}), 64'({edv, epv}));
      if (edv) chk("rnd_ddata", 64'(bus.disp_read_data), 64'(edata));
      if (epv) chk("rnd_pdata", 64'(bus.proc_read_data), 64'(edata));
      m_ca = (sel == 2'd2); m_pa = (sel == 2'd3);

      if (i >= 1490) begin
        idle_inputs();
      end else begin
        bus.disp_req = ($urandom_range(3) == 0);
        bus.disp_addr = 19'($urandom);
        if (m_ca) bus.cam_req = $urandom_range(1);
        else if (bus.cam_req && $urandom_range(31) == 0) bus.cam_req = 0;
        else if (!bus.cam_req) bus.cam_req = ($urandom_range(2) == 0);
        if (bus.cam_req && (m_ca || !sc)) begin
          bus.cam_addr = 19'($urandom); bus.cam_write_data = {4'($urandom), 32'($urandom)};
        end
        if (m_pa) bus.proc_req = $urandom_range(1);
        else if (bus.proc_req && $urandom_range(31) == 0) bus.proc_req = 0;
        else if (!bus.proc_req) bus.proc_req = ($urandom_range(2) == 0);
        if (bus.proc_req && (m_pa || !sp)) begin
          bus.proc_we = $urandom_range(1); bus.proc_addr = 19'($urandom);
          bus.proc_write_data = {4'($urandom), 32'($urandom)};
        end
      end
    end
    chk("rnd_drained", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
